// File: rtl/ibm_rx.sv
// ---------------------------------------------------------------------------
// ibm_rx - input buffer manager, receive side.
//
// Takes the 134-bit line stream plus TSN metadata from the ingress action
// stage, allocates a buffer ID from a free pool, and writes each line into
// the shared packet RAM at {ID,line}. A good packet end emits a descriptor
// {ID, last line, md[23:8]} to the queue manager. A bad or oversize packet
// returns its ID to the pool instead.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   in_ibm_data/_wr         line + strobe ([133:132] 01 head, 11 body, 10 tail)
//   in_ibm_valid/_wr        end-of-packet strobe and good/bad flag
//   in_ibm_tsn_md/_wr       TSN metadata + strobe
//   in_ibm_free_id/_wr      ID released by the transmit side
//   out_ibm_bufm_ID_count   free IDs in the pool
//   out_ibm_ram_*           packet RAM write port
//   out_ibm_desc/_wr        descriptor + one-cycle strobe
//   out_ibm_pkt_cnt         committed packets
//   out_ibm_drop_cnt        dropped packets
//   out_ibm_err             sticky: release refused because the pool was full
// ---------------------------------------------------------------------------
module ibm_rx #(
    parameter int ID_NUM = 32,
    parameter int ID_W   = 5,
    parameter int LINE_W = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [133:0]              in_ibm_data,
    input  logic                      in_ibm_data_wr,
    input  logic                      in_ibm_valid,
    input  logic                      in_ibm_valid_wr,
    input  logic [23:0]               in_ibm_tsn_md,
    input  logic                      in_ibm_tsn_md_wr,
    output logic [5:0]                out_ibm_bufm_ID_count,
    output logic                      out_ibm_ram_wr,
    output logic [ID_W+LINE_W-1:0]    out_ibm_ram_addr,
    output logic [133:0]              out_ibm_ram_data,
    output logic [ID_W+LINE_W+15:0]   out_ibm_desc,
    output logic                      out_ibm_desc_wr,
    input  logic [ID_W-1:0]           in_ibm_free_id,
    input  logic                      in_ibm_free_id_wr,
    output logic [31:0]               out_ibm_pkt_cnt,
    output logic [31:0]               out_ibm_drop_cnt,
    output logic                      out_ibm_err
);

    localparam int AW = ID_W + LINE_W;
    localparam int DW = AW + 16;
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(ID_NUM - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WR, S_DISC} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     init_q, init_d;
    logic [ID_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [15:0]         md_q, md_d;
    logic                ram_wr_q, ram_wr_d;
    logic [AW-1:0]       ram_addr_q, ram_addr_d;
    logic [133:0]        ram_data_q, ram_data_d;
    logic [DW-1:0]       desc_q, desc_d;
    logic                desc_wr_q, desc_wr_d;
    logic [31:0]         pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
    logic                err_q, err_d;

    logic [ID_W-1:0]     fifo_mem [ID_NUM];
    logic [ID_W-1:0]     pop_id, int_id, push0_id, push1_id, wr_ptr_p1;
    logic                pop, int_ret, ext_ok, push0, push1;
    logic                is_head, is_tail;
    logic [15:0]         md_cur;
    logic [LINE_W-1:0]   line_last;
    logic [6:0]          room;

    logic unused_md;
    assign unused_md = &{1'b0, in_ibm_tsn_md[7:0]};

    // Pool pointers wrap at ID_NUM, which need not be a power of two.
    function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] p);
        return (p == ID_LAST) ? '0 : p + 1'b1;
    endfunction

    assign pop_id    = fifo_mem[rd_ptr_q];
    assign wr_ptr_p1 = nxt(wr_ptr_q);
    assign is_head   = (in_ibm_data[133:132] == 2'b01);
    assign is_tail   = (in_ibm_data[133:132] == 2'b10);
    assign md_cur    = in_ibm_tsn_md_wr ? in_ibm_tsn_md[23:8] : md_q;
    assign line_last = in_ibm_data_wr ? line_q + 1'b1 : line_q;

    always_comb begin
        state_d    = state_q;
        init_d     = init_q;
        id_d       = id_q;
        line_d     = line_q;
        md_d       = md_q;
        ram_wr_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        desc_d     = desc_q;
        desc_wr_d  = 1'b0;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        pop        = 1'b0;
        int_ret    = 1'b0;
        int_id     = id_q;

        case (state_q)
            S_INIT: begin
                init_d = init_q + 1'b1;
                if (init_q == ID_LAST) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (in_ibm_data_wr && is_head) begin
                    if (cnt_q == '0) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        state_d    = in_ibm_valid_wr ? S_IDLE : S_DISC;
                    end else begin
                        pop        = 1'b1;
                        id_d       = pop_id;
                        md_d       = md_cur;
                        line_d     = '0;
                        ram_wr_d   = 1'b1;
                        ram_addr_d = {pop_id, {LINE_W{1'b0}}};
                        ram_data_d = in_ibm_data;
                        if (!in_ibm_valid_wr) begin
                            state_d = S_WR;
                        end else if (in_ibm_valid) begin
                            // single-line packet commits on the spot
                            desc_d    = {pop_id, {LINE_W{1'b0}}, md_cur};
                            desc_wr_d = 1'b1;
                            pkt_cnt_d = pkt_cnt_q + 32'd1;
                        end else begin
                            int_ret    = 1'b1;
                            int_id     = pop_id;
                            drop_cnt_d = drop_cnt_q + 32'd1;
                        end
                    end
                end
            end
            S_WR: begin
                if (in_ibm_tsn_md_wr) md_d = in_ibm_tsn_md[23:8];
                if (in_ibm_data_wr && line_q == {LINE_W{1'b1}}) begin
                    // buffer full: give the ID back and discard the rest
                    int_ret    = 1'b1;
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    state_d    = in_ibm_valid_wr ? S_IDLE : S_DISC;
                end else begin
                    if (in_ibm_data_wr) begin
                        line_d     = line_last;
                        ram_wr_d   = 1'b1;
                        ram_addr_d = {id_q, line_last};
                        ram_data_d = in_ibm_data;
                    end
                    if (in_ibm_valid_wr) begin
                        state_d = S_IDLE;
                        if (in_ibm_valid) begin
                            desc_d    = {id_q, line_last, md_cur};
                            desc_wr_d = 1'b1;
                            pkt_cnt_d = pkt_cnt_q + 32'd1;
                        end else begin
                            int_ret    = 1'b1;
                            drop_cnt_d = drop_cnt_q + 32'd1;
                        end
                    end
                end
            end
            S_DISC: begin
                if (in_ibm_valid_wr || (in_ibm_data_wr && is_tail)) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Pool pushes: INIT fill, internal return and external release. The last
    // two may coincide and are written as two consecutive entries. A release
    // is refused if it would take the pool past ID_NUM.
    always_comb begin
        room     = {1'b0, cnt_q} + 7'(int_ret) - 7'(pop);
        ext_ok   = in_ibm_free_id_wr && (state_q != S_INIT) && (room < 7'(ID_NUM));
        err_d    = err_q | (in_ibm_free_id_wr && (state_q != S_INIT) && !ext_ok);
        push0    = 1'b0;
        push1    = 1'b0;
        push0_id = init_q;
        push1_id = in_ibm_free_id;
        if (state_q == S_INIT) begin
            push0 = 1'b1;
        end else if (int_ret) begin
            push0    = 1'b1;
            push0_id = int_id;
            push1    = ext_ok;
        end else if (ext_ok) begin
            push0    = 1'b1;
            push0_id = in_ibm_free_id;
        end
        cnt_d    = cnt_q + 6'(push0) + 6'(push1) - 6'(pop);
        rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push1 ? nxt(wr_ptr_p1) : (push0 ? wr_ptr_p1 : wr_ptr_q);
    end

    always_ff @(posedge clk) begin
        if (push0) fifo_mem[wr_ptr_q]  <= push0_id;
        if (push1) fifo_mem[wr_ptr_p1] <= push1_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            id_q       <= '0;
            line_q     <= '0;
            md_q       <= '0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            desc_q     <= '0;
            desc_wr_q  <= 1'b0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            line_q     <= line_d;
            md_q       <= md_d;
            ram_wr_q   <= ram_wr_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            desc_q     <= desc_d;
            desc_wr_q  <= desc_wr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
        end
    end

    assign out_ibm_bufm_ID_count = cnt_q;
    assign out_ibm_ram_wr        = ram_wr_q;
    assign out_ibm_ram_addr      = ram_addr_q;
    assign out_ibm_ram_data      = ram_data_q;
    assign out_ibm_desc          = desc_q;
    assign out_ibm_desc_wr       = desc_wr_q;
    assign out_ibm_pkt_cnt       = pkt_cnt_q;
    assign out_ibm_drop_cnt      = drop_cnt_q;
    assign out_ibm_err           = err_q;

endmodule

// File: tb/tb_ibm_rx.sv
// ---------------------------------------------------------------------------
// tb_ibm_rx - directed bench for ibm_rx (ID_NUM=32, ID_W=5, LINE_W=7).
// A short vector table covers the basic packet flows; longer sequences use a
// free-ID queue model for pool exhaustion, reuse, oversize, release corners
// and reset mid-packet.
// ---------------------------------------------------------------------------
module tb_ibm_rx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [133:0] data;
    logic         dwr, vld, vwr, mdwr, fwr;
    logic [23:0]  md;
    logic [4:0]   fid;
    logic [5:0]   cnt;
    logic         ram_wr, desc_wr, err;
    logic [11:0]  ram_addr;
    logic [133:0] ram_data;
    logic [27:0]  desc;
    logic [31:0]  pkt_cnt, drop_cnt;

    always #5 clk = ~clk;

    ibm_rx dut (
        .clk(clk), .rst_n(rst_n),
        .in_ibm_data(data), .in_ibm_data_wr(dwr),
        .in_ibm_valid(vld), .in_ibm_valid_wr(vwr),
        .in_ibm_tsn_md(md), .in_ibm_tsn_md_wr(mdwr),
        .out_ibm_bufm_ID_count(cnt),
        .out_ibm_ram_wr(ram_wr), .out_ibm_ram_addr(ram_addr), .out_ibm_ram_data(ram_data),
        .out_ibm_desc(desc), .out_ibm_desc_wr(desc_wr),
        .in_ibm_free_id(fid), .in_ibm_free_id_wr(fwr),
        .out_ibm_pkt_cnt(pkt_cnt), .out_ibm_drop_cnt(drop_cnt), .out_ibm_err(err)
    );

    int nchk = 0, nerr = 0;
    int fq[$];
    int hq[$];
    int e_pkt, e_drop;
    bit e_err;

    typedef struct {
        bit dwr; logic [1:0] typ; bit vwr; bit vld; bit mdwr; logic [23:0] md;
        bit fwr; logic [4:0] fid;
        bit e_wr; logic [11:0] e_addr; bit e_dwr; logic [27:0] e_desc;
        int e_cnt; int e_pkt; int e_drop;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        dwr = 0; data = '0; vld = 0; vwr = 0; mdwr = 0; md = '0; fwr = 0; fid = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        fq.delete(); hq.delete();
        for (int i = 0; i < 32; i++) fq.push_back(i);
        e_pkt = 0; e_drop = 0; e_err = 0;
    endtask

    // Reset just released: watch the pool fill, lines offered meanwhile are dropped.
    task automatic init_phase();
        for (int j = 0; j < 34; j++) begin
            if (j < 10) begin
                dwr = 1; data = {2'b01, 4'h1, 128'(j)};
            end else idle();
            step();
            chk("init_ram_wr", 134'(ram_wr), 134'(0));
            chk("init_cnt", 134'(cnt), 134'((j + 1 > 32) ? 32 : j + 1));
        end
        chk("init_drop", 134'(drop_cnt), 134'(0));
        idle();
        model_reset();
    endtask

    task automatic rel(input logic [4:0] id);
        idle(); fwr = 1; fid = id;
        if (fq.size() < 32) fq.push_back(int'(id)); else e_err = 1;
        step(); idle();
        chk("rel_cnt", 134'(cnt), 134'(fq.size()));
        chk("rel_err", 134'(err), 134'(e_err));
        chk("rel_ram_wr", 134'(ram_wr), 134'(0));
    endtask

    // n-line packet; optional release driven alongside the head line.
    task automatic pkt(input int n, input bit good, input logic [23:0] pmd,
                       input bit rwr, input logic [4:0] rid);
        logic [4:0]   id;
        logic [1:0]   typ;
        logic [133:0] d;
        logic [11:0]  e_addr;
        logic [27:0]  e_desc;
        bit have, e_wr, e_dwr, last;
        have = 0; id = '0;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            typ  = (i == 0) ? 2'b01 : (last ? 2'b10 : 2'b11);
            d    = {typ, 4'hA, 128'(i * 7 + n)};
            e_wr = 0; e_dwr = 0; e_addr = '0; e_desc = '0;
            if (i == 0) begin
                if (fq.size() > 0) begin id = 5'(fq.pop_front()); have = 1; end
                else e_drop++;
                if (rwr) begin
                    if (fq.size() < 32) fq.push_back(int'(rid)); else e_err = 1;
                end
            end
            if (have) begin
                if (i > 127) begin
                    have = 0; e_drop++; fq.push_back(int'(id));
                end else begin
                    e_wr = 1; e_addr = {id, 7'(i)};
                    if (last) begin
                        have = 0;
                        if (good) begin
                            e_dwr = 1; e_desc = {id, 7'(i), pmd[23:8]};
                            e_pkt++; hq.push_back(int'(id));
                        end else begin
                            e_drop++; fq.push_back(int'(id));
                        end
                    end
                end
            end
            dwr = 1; data = d; mdwr = (i == 0); md = pmd; vwr = last; vld = good;
            fwr = (i == 0) && rwr; fid = rid;
            step();
            chk("pkt_ram_wr", 134'(ram_wr), 134'(e_wr));
            if (e_wr) begin
                chk("pkt_ram_addr", 134'(ram_addr), 134'(e_addr));
                chk("pkt_ram_data", ram_data, d);
            end
            chk("pkt_desc_wr", 134'(desc_wr), 134'(e_dwr));
            if (e_dwr) chk("pkt_desc", 134'(desc), 134'(e_desc));
            chk("pkt_cnt_free", 134'(cnt), 134'(fq.size()));
            chk("pkt_pkt_cnt", 134'(pkt_cnt), 134'(e_pkt));
            chk("pkt_drop_cnt", 134'(drop_cnt), 134'(e_drop));
            chk("pkt_err", 134'(err), 134'(e_err));
        end
        idle();
    endtask

    initial begin
        logic [4:0] r;
        //        dwr typ   vwr vld mdwr md         fwr fid   wr addr    dwr desc          cnt pkt drop
        tv[0]  = '{1, 2'b01, 0, 0, 1, 24'h4AB300, 0, 5'd0, 1, 12'h000, 0, 28'h0,        31, 0, 0};
        tv[1]  = '{1, 2'b11, 0, 0, 0, 24'h0,      0, 5'd0, 1, 12'h001, 0, 28'h0,        31, 0, 0};
        tv[2]  = '{1, 2'b11, 0, 0, 0, 24'h0,      0, 5'd0, 1, 12'h002, 0, 28'h0,        31, 0, 0};
        tv[3]  = '{1, 2'b10, 1, 1, 0, 24'h0,      0, 5'd0, 1, 12'h003, 1, 28'h0034AB3,  31, 1, 0};
        tv[4]  = '{0, 2'b00, 0, 0, 0, 24'h0,      1, 5'd0, 0, 12'h000, 0, 28'h0,        32, 1, 0};
        tv[5]  = '{1, 2'b01, 0, 0, 1, 24'h123400, 0, 5'd0, 1, 12'h080, 0, 28'h0,        31, 1, 0};
        tv[6]  = '{1, 2'b11, 0, 0, 0, 24'h0,      0, 5'd0, 1, 12'h081, 0, 28'h0,        31, 1, 0};
        tv[7]  = '{1, 2'b10, 1, 0, 0, 24'h0,      0, 5'd0, 1, 12'h082, 0, 28'h0,        32, 1, 1};
        tv[8]  = '{1, 2'b11, 0, 0, 0, 24'h0,      0, 5'd0, 0, 12'h000, 0, 28'h0,        32, 1, 1};
        tv[9]  = '{1, 2'b10, 1, 1, 0, 24'h0,      0, 5'd0, 0, 12'h000, 0, 28'h0,        32, 1, 1};
        tv[10] = '{1, 2'b01, 1, 1, 1, 24'h800000, 0, 5'd0, 1, 12'h100, 1, 28'h1008000,  31, 2, 1};
        tv[11] = '{0, 2'b00, 0, 0, 0, 24'h0,      1, 5'd2, 0, 12'h000, 0, 28'h0,        32, 2, 1};

        idle();
        #22;
        chk("rst_cnt", 134'(cnt), 134'(0));
        chk("rst_ram_wr", 134'(ram_wr), 134'(0));
        chk("rst_desc_wr", 134'(desc_wr), 134'(0));
        chk("rst_pkt", 134'(pkt_cnt), 134'(0));
        chk("rst_err", 134'(err), 134'(0));
        rst_n = 1'b1;
        init_phase();

        for (int k = 0; k < 12; k++) begin
            dwr = tv[k].dwr; data = {tv[k].typ, 4'h5, 128'(k + 100)};
            vwr = tv[k].vwr; vld = tv[k].vld; mdwr = tv[k].mdwr; md = tv[k].md;
            fwr = tv[k].fwr; fid = tv[k].fid;
            step();
            chk("tv_ram_wr", 134'(ram_wr), 134'(tv[k].e_wr));
            if (tv[k].e_wr) begin
                chk("tv_ram_addr", 134'(ram_addr), 134'(tv[k].e_addr));
                chk("tv_ram_data", ram_data, {tv[k].typ, 4'h5, 128'(k + 100)});
            end
            chk("tv_desc_wr", 134'(desc_wr), 134'(tv[k].e_dwr));
            if (tv[k].e_dwr) chk("tv_desc", 134'(desc), 134'(tv[k].e_desc));
            chk("tv_cnt", 134'(cnt), 134'(tv[k].e_cnt));
            chk("tv_pkt", 134'(pkt_cnt), 134'(tv[k].e_pkt));
            chk("tv_drop", 134'(drop_cnt), 134'(tv[k].e_drop));
        end
        idle();

        // pool order after the table: 3..31 then the returned 0,1,2
        fq.delete(); hq.delete();
        for (int i = 3; i < 32; i++) fq.push_back(i);
        for (int i = 0; i < 3; i++) fq.push_back(i);
        e_pkt = 2; e_drop = 1; e_err = 0;

        // exhaust the pool, then one more packet must be dropped
        for (int k = 0; k < 32; k++) pkt(2, 1, 24'(k * 256 + 24'h010000), 0, 5'd0);
        chk("exhaust_cnt", 134'(cnt), 134'(0));
        pkt(3, 1, 24'hABCD00, 0, 5'd0);
        chk("drop_33rd", 134'(drop_cnt), 134'(e_drop));

        // a single release is reused by the next packet
        r = 5'(hq.pop_front());
        rel(r);
        pkt(2, 1, 24'h111100, 0, 5'd0);
        chk("reuse_id", 134'(hq[hq.size() - 1]), 134'(r));

        // release alongside a head pop at count 5
        for (int k = 0; k < 5; k++) rel(5'(hq.pop_front()));
        chk("cnt_five", 134'(cnt), 134'(5));
        r = 5'(hq.pop_front());
        pkt(2, 1, 24'h222200, 1, r);
        chk("cnt_pop_rel", 134'(cnt), 134'(5));

        // refill and over-release
        while (hq.size() > 0) rel(5'(hq.pop_front()));
        chk("full_cnt", 134'(cnt), 134'(32));
        rel(5'd7);
        chk("full_err", 134'(err), 134'(1));

        // oversize, then single-line good and bad packets
        pkt(130, 1, 24'h333300, 0, 5'd0);
        chk("oversize_cnt", 134'(cnt), 134'(32));
        pkt(1, 1, 24'h444400, 0, 5'd0);
        pkt(1, 0, 24'h555500, 0, 5'd0);

        // reset in the middle of a packet
        dwr = 1; data = {2'b01, 4'h0, 128'(1)}; step();
        data = {2'b11, 4'h0, 128'(2)}; step();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cnt", 134'(cnt), 134'(0));
        chk("midrst_pkt", 134'(pkt_cnt), 134'(0));
        chk("midrst_err", 134'(err), 134'(0));
        @(negedge clk);
        rst_n = 1'b1;
        init_phase();
        pkt(2, 1, 24'h666600, 0, 5'd0);
        chk("post_rst_desc_id", 134'(hq[0]), 134'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
